// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory arbiter and LSU helpers.
package dmem_pkg;

  // Access size encoding: bytes-1. 2'b10 is reserved and always rejected.
  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_ILL  = 2'b10;
  localparam logic [1:0] DSIZE_WORD = 2'b11;

  // Default starvation settings; the counter must be able to hold the limit.
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int CNT_W_DEF        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester A, requester B and dmem-side signals around the arbiter.
//
// Handshake: a requester raises x_req with its fields stable and keeps them
// stable until it sees x_gnt (a one-cycle pulse, only in IDLE). Exactly two
// cycles after x_gnt the arbiter pulses x_rvalid for one cycle with x_rdata
// and x_err; stores complete with rdata=0. There is no backpressure on the
// response side: the requester must accept x_rvalid when it appears.
interface dmem_arbiter_if #(
  parameter int CNT_W = dmem_pkg::CNT_W_DEF
);
  import dmem_pkg::*;

  logic          a_req,    b_req;
  logic [0:31]   a_addr,   b_addr;
  logic [0:31]   a_wdata,  b_wdata;
  logic          a_we,     b_we;
  logic [0:1]    a_dsize,  b_dsize;
  logic          a_dsign,  b_dsign;
  logic          a_gnt,    b_gnt;
  logic          a_rvalid, b_rvalid;
  logic [0:31]   a_rdata,  b_rdata;
  logic          a_err,    b_err;

  logic [0:31]   m_addr;
  logic [0:31]   m_wData;
  logic          m_writeEnable;
  logic [0:1]    m_dsize;
  logic          m_dsign;
  logic [0:31]   m_rData;

  // Debug visibility of the arbiter FSM and starvation counter.
  state_t        dbg_state;
  logic [CNT_W-1:0] dbg_starve;

  // Arbiter side.
  modport slave (
    input  a_req, a_addr, a_wdata, a_we, a_dsize, a_dsign,
    input  b_req, b_addr, b_wdata, b_we, b_dsize, b_dsign,
    output a_gnt, a_rvalid, a_rdata, a_err,
    output b_gnt, b_rvalid, b_rdata, b_err,
    output m_addr, m_wData, m_writeEnable, m_dsize, m_dsign,
    input  m_rData,
    output dbg_state, dbg_starve
  );

  // Requester / memory-model side.
  modport master (
    output a_req, a_addr, a_wdata, a_we, a_dsize, a_dsign,
    output b_req, b_addr, b_wdata, b_we, b_dsize, b_dsign,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    input  b_gnt, b_rvalid, b_rdata, b_err,
    input  m_addr, m_wData, m_writeEnable, m_dsize, m_dsign,
    output m_rData,
    input  dbg_state, dbg_starve
  );

endinterface

// File: rtl/dmem_align_check.sv
// Combinational alignment/size check for a data-memory access.
module dmem_align_check
  import dmem_pkg::*;
(
  input  logic [0:31] addr_i,
  input  logic [0:1]  dsize_i,
  output logic        err_o
);

  // Word needs the two low address bits clear, half needs the lowest bit
  // clear, byte is always fine, and the reserved size is always an error.
  always_comb begin
    err_o = 1'b0;
    case (dsize_i)
      DSIZE_WORD: err_o = (addr_i[30:31] != 2'b00);
      DSIZE_HALF: err_o = addr_i[31];
      DSIZE_ILL:  err_o = 1'b1;
      default:    err_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory. One access
// takes three cycles (IDLE grant, ISSUE to dmem, RESP to the owner).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q,  state_d;
  owner_t            owner_q,  owner_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [0:31]       addr_q,   addr_d;
  logic [0:31]       wdata_q,  wdata_d;
  logic [0:31]       rdata_q,  rdata_d;
  logic              we_q,     we_d;
  logic [0:1]        dsize_q,  dsize_d;
  logic              dsign_q,  dsign_d;
  logic              err_q,    err_d;

  logic              grant_ok;
  logic              b_wins;
  logic              a_gnt;
  logic              b_gnt;
  logic [0:31]       sel_addr;
  logic [0:1]        sel_dsize;
  logic              sel_err;
  logic              resp_ok;

  // Pick the winner: A by default, B when A is idle or B has starved too long.
  always_comb begin
    grant_ok  = (state_q == ST_IDLE) && !rst;
    b_wins    = bus.b_req && (!bus.a_req || (starve_q >= LIMIT));
    b_gnt     = grant_ok && b_wins;
    a_gnt     = grant_ok && bus.a_req && !b_wins;
    sel_addr  = b_wins ? bus.b_addr  : bus.a_addr;
    sel_dsize = b_wins ? bus.b_dsize : bus.a_dsize;
  end

  dmem_align_check u_align (
    .addr_i  (sel_addr),
    .dsize_i (sel_dsize),
    .err_o   (sel_err)
  );

  // Next state, request latch, load-data capture and starvation counter.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    dsize_d  = dsize_q;
    dsign_d  = dsign_q;
    err_d    = err_q;

    // B losing while requesting counts up; B winning or going quiet clears it.
    if (!bus.b_req || b_gnt) begin
      starve_d = '0;
    end else if (a_gnt && (starve_q != '1)) begin
      starve_d = starve_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (a_gnt || b_gnt) begin
          state_d = ST_ISSUE;
          owner_d = b_gnt ? ID_B : ID_A;
          addr_d  = sel_addr;
          dsize_d = sel_dsize;
          err_d   = sel_err;
          wdata_d = b_gnt ? bus.b_wdata : bus.a_wdata;
          we_d    = b_gnt ? bus.b_we    : bus.a_we;
          dsign_d = b_gnt ? bus.b_dsign : bus.a_dsign;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
        rdata_d = (we_q || err_q) ? '0 : bus.m_rData;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= ID_A;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      dsize_q  <= DSIZE_WORD;
      dsign_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      dsize_q  <= dsize_d;
      dsign_q  <= dsign_d;
      err_q    <= err_d;
    end
  end

  // Requester responses, dmem drive and debug taps. The m_* fields come
  // straight from the latch, which only changes on a grant edge, so they
  // hold the last issued access outside ISSUE.
  always_comb begin
    resp_ok      = (state_q == ST_RESP) && !rst;
    bus.a_gnt    = a_gnt;
    bus.b_gnt    = b_gnt;
    bus.a_rvalid = resp_ok && (owner_q == ID_A);
    bus.b_rvalid = resp_ok && (owner_q == ID_B);
    bus.a_rdata  = bus.a_rvalid ? rdata_q : '0;
    bus.b_rdata  = bus.b_rvalid ? rdata_q : '0;
    bus.a_err    = bus.a_rvalid && err_q;
    bus.b_err    = bus.b_rvalid && err_q;

    bus.m_addr        = addr_q;
    bus.m_wData       = wdata_q;
    bus.m_dsize       = dsize_q;
    bus.m_dsign       = dsign_q;
    bus.m_writeEnable = (state_q == ST_ISSUE) && we_q && !err_q && !rst;

    bus.dbg_state  = state_q;
    bus.dbg_starve = starve_q;
  end

endmodule
